spi_sck_gen: RTL and testbench

- Parametrised SPI master serial-clock and transfer-timing engine.
- Generates SCK for all four CPOL/CPHA modes, a one-cycle load strobe and per-edge sample/shift strobes, and a programmable chip-select lead/lag gap.
- Counts edges for a configurable transfer length, then signals completion.
- Sits between the SPI register block and the shift-register datapath. Replaces the fixed free-running divider with a self-terminating, transfer-aware engine.

---
 rtl/spi_pkg.sv | 50 +++++
 rtl/spi_div_tick.sv | 54 +++++
 rtl/spi_sck_gen.sv | 255 +++++++++++++++++++++++++
 tb/tb_spi_sck_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI serial-clock / transfer-timing engine.
//   - default widths for the divider, bit-count and CS delay fields
//   - transfer FSM state encoding
//   - the latched {cpol, cpha} mode pair
//   - a helper that decodes which strobe an SCK edge produces
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int DIV_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF = 6;
  localparam int DLY_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAD = 2'd1,
    ST_XFER = 2'd2,
    ST_LAG  = 2'd3
  } state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef struct packed {
    logic sample;
    logic shift;
  } edge_strobe_t;

  // Leading edges are the even-numbered ones. With CPHA=0 the slave has
  // already driven the first bit before SCK starts, so we sample on leading
  // edges and shift on trailing ones; the final trailing edge has no next
  // bit to present. CPHA=1 is the mirror image.
  function automatic edge_strobe_t edge_strobes(input logic cpha,
                                                input logic trailing,
                                                input logic last_edge);
    edge_strobe_t s;
    if (!cpha) begin
      s.sample = ~trailing;
      s.shift  = trailing & ~last_edge;
    end else begin
      s.sample = trailing;
      s.shift  = ~trailing;
    end
    return s;
  endfunction

endpackage

// File: rtl/spi_div_tick.sv
// ---------------------------------------------------------------------------
// spi_div_tick
// Reloadable down-counter that produces the half-period tick for the SPI
// engine. One instance serves the LEAD, XFER and LAG phases.
// Ports:
//   clk_i     system clock
//   rst_n_i   asynchronous active-low reset
//   reload_i  force the counter to div_i this cycle
//   en_i      tick qualifier; tick_o is only asserted while enabled
//   div_i     reload value (half-period minus one)
//   tick_o    high in the cycle the counter reaches zero while enabled
// ---------------------------------------------------------------------------
module spi_div_tick
  import spi_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 reload_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  localparam logic [DIV_WIDTH-1:0] ONE_DIV = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic                 at_zero;

  assign at_zero = (cnt_q == '0);
  assign tick_o  = en_i & at_zero;

  // Reaching zero always reloads, so the counter never wraps through the
  // top of its range; a div_i of zero therefore ticks every cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (reload_i || at_zero) begin
      cnt_d = div_i;
    end else if (en_i) begin
      cnt_d = cnt_q - ONE_DIV;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_sck_gen.sv
// ---------------------------------------------------------------------------
// spi_sck_gen
// SPI master serial-clock and transfer-timing engine. On a start request it
// latches the transfer configuration, drops chip select, waits a lead gap,
// emits 2N SCK edges with sample/shift strobes, waits a lag gap, then raises
// chip select and pulses done.
// Ports:
//   clk_i      system clock
//   rst_n_i    asynchronous active-low reset
//   start_i    start request, honoured only when idle
//   abort_i    abandon the current transfer (no done pulse)
//   cpol_i     SCK idle level
//   cpha_i     0: sample on leading edge, 1: shift on leading edge
//   clk_div_i  half-period minus one, in clk_i cycles
//   bit_num_i  bits per transfer, 0 selects 2^CNT_WIDTH
//   cs_dly_i   CS lead and lag gap in half-periods, 0 behaves as 1
//   busy_o     transfer in progress
//   cs_n_o     chip select, active low
//   sck_o      serial clock
//   load_o     one-cycle pulse: present the first MOSI bit
//   sample_o   one-cycle pulse: capture MISO
//   shift_o    one-cycle pulse: advance MOSI
//   done_o     one-cycle pulse at the end of a completed transfer
// ---------------------------------------------------------------------------
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int DLY_WIDTH = DLY_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 cpol_i,
  input  logic                 cpha_i,
  input  logic [DIV_WIDTH-1:0] clk_div_i,
  input  logic [CNT_WIDTH-1:0] bit_num_i,
  input  logic [DLY_WIDTH-1:0] cs_dly_i,
  output logic                 busy_o,
  output logic                 cs_n_o,
  output logic                 sck_o,
  output logic                 load_o,
  output logic                 sample_o,
  output logic                 shift_o,
  output logic                 done_o
);

  // Edge indices run 0..2N-1, which needs one bit more than the bit count.
  localparam int EW = CNT_WIDTH + 1;
  localparam logic [EW-1:0]        ONE_EDGE = EW'(1);
  localparam logic [DLY_WIDTH-1:0] ONE_DLY  = DLY_WIDTH'(1);

  state_e               state_q,     state_d;
  spi_mode_t            mode_q,      mode_d;
  logic [DIV_WIDTH-1:0] clk_div_q,   clk_div_d;
  logic [EW-1:0]        last_edge_q, last_edge_d;
  logic [DLY_WIDTH-1:0] dly_last_q,  dly_last_d;
  logic [EW-1:0]        edge_cnt_q,  edge_cnt_d;
  logic [DLY_WIDTH-1:0] dly_cnt_q,   dly_cnt_d;

  logic sck_q,    sck_d;
  logic cs_n_q,   cs_n_d;
  logic busy_q,   busy_d;
  logic load_q,   load_d;
  logic sample_q, sample_d;
  logic shift_q,  shift_d;
  logic done_q,   done_d;

  logic                 tick;
  logic                 div_reload;
  logic [DIV_WIDTH-1:0] div_val;
  logic                 start_ok;
  logic                 edge_fire;
  logic [EW-1:0]        edge_idx;
  edge_strobe_t         strobe;

  // Abort beats a simultaneous start.
  assign start_ok = (state_q == ST_IDLE) & start_i & ~abort_i;

  // While idle the divider tracks the live input so the first lead
  // half-period already uses the value sampled with start_i; afterwards
  // only the latched copy matters.
  assign div_val    = (state_q == ST_IDLE) ? clk_div_i : clk_div_q;
  assign div_reload = (state_q == ST_IDLE) | (state_d != state_q);

  spi_div_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_div_tick (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .reload_i (div_reload),
    .en_i     (state_q != ST_IDLE),
    .div_i    (div_val),
    .tick_o   (tick)
  );

  // The final LEAD tick produces edge 0; every XFER tick produces the edge
  // held in the edge counter.
  assign edge_idx = (state_q == ST_LEAD) ? '0 : edge_cnt_q;
  assign strobe   = edge_strobes(mode_q.cpha, edge_idx[0],
                                 edge_idx == last_edge_q);

  // Next-state and output computation. The LEAD->XFER transition coincides
  // with edge 0 and XFER->LAG with the last edge, so each phase boundary
  // is a tick and the divider reload on state entry lines up with it.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    clk_div_d   = clk_div_q;
    last_edge_d = last_edge_q;
    dly_last_d  = dly_last_q;
    edge_cnt_d  = edge_cnt_q;
    dly_cnt_d   = dly_cnt_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    busy_d      = busy_q;
    load_d      = 1'b0;
    sample_d    = 1'b0;
    shift_d     = 1'b0;
    done_d      = 1'b0;
    edge_fire   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sck_d  = cpol_i;
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        if (start_ok) begin
          state_d     = ST_LEAD;
          mode_d.cpol = cpol_i;
          mode_d.cpha = cpha_i;
          clk_div_d   = clk_div_i;
          // 2N-1 in EW bits: a bit count of zero wraps to the all-ones
          // index, which is exactly the last edge of a 2^CNT_WIDTH transfer.
          last_edge_d = {bit_num_i, 1'b0} - ONE_EDGE;
          dly_last_d  = (cs_dly_i == '0) ? '0 : (cs_dly_i - ONE_DLY);
          edge_cnt_d  = '0;
          dly_cnt_d   = '0;
          cs_n_d      = 1'b0;
          busy_d      = 1'b1;
          load_d      = 1'b1;
        end
      end

      ST_LEAD: begin
        if (tick) begin
          if (dly_cnt_q == dly_last_q) begin
            state_d    = ST_XFER;
            edge_fire  = 1'b1;
            edge_cnt_d = ONE_EDGE;
          end else begin
            dly_cnt_d = dly_cnt_q + ONE_DLY;
          end
        end
      end

      ST_XFER: begin
        if (tick) begin
          edge_fire = 1'b1;
          if (edge_cnt_q == last_edge_q) begin
            state_d   = ST_LAG;
            dly_cnt_d = '0;
          end else begin
            edge_cnt_d = edge_cnt_q + ONE_EDGE;
          end
        end
      end

      ST_LAG: begin
        if (tick) begin
          if (dly_cnt_q == dly_last_q) begin
            state_d    = ST_IDLE;
            cs_n_d     = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            edge_cnt_d = '0;
            dly_cnt_d  = '0;
          end else begin
            dly_cnt_d = dly_cnt_q + ONE_DLY;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (edge_fire) begin
      sck_d    = ~sck_q;
      sample_d = strobe.sample;
      shift_d  = strobe.shift;
    end

    // Abort drops everything back to idle with SCK parked at the latched
    // polarity; no done pulse is produced.
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      sck_d      = mode_q.cpol;
      cs_n_d     = 1'b1;
      busy_d     = 1'b0;
      load_d     = 1'b0;
      sample_d   = 1'b0;
      shift_d    = 1'b0;
      done_d     = 1'b0;
      edge_cnt_d = '0;
      dly_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      clk_div_q   <= '0;
      last_edge_q <= '0;
      dly_last_q  <= '0;
      edge_cnt_q  <= '0;
      dly_cnt_q   <= '0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      load_q      <= 1'b0;
      sample_q    <= 1'b0;
      shift_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      clk_div_q   <= clk_div_d;
      last_edge_q <= last_edge_d;
      dly_last_q  <= dly_last_d;
      edge_cnt_q  <= edge_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      load_q      <= load_d;
      sample_q    <= sample_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
    end
  end

  assign busy_o   = busy_q;
  assign cs_n_o   = cs_n_q;
  assign sck_o    = sck_q;
  assign load_o   = load_q;
  assign sample_o = sample_q;
  assign shift_o  = shift_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_spi_sck_gen.sv
// ---------------------------------------------------------------------------
// tb_spi_sck_gen
// Scoreboard bench for spi_sck_gen. Each transfer's expected event list
// (load, every SCK edge with its strobe, done) is computed from the timing
// formulas and queued; a monitor pops and compares whenever the DUT shows
// an event.
// ---------------------------------------------------------------------------
module tb_spi_sck_gen;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        cpol_i = 1'b0;
  logic        cpha_i = 1'b0;
  logic [15:0] clk_div_i = '0;
  logic [5:0]  bit_num_i = '0;
  logic [3:0]  cs_dly_i = '0;
  logic        busy_o, cs_n_o, sck_o, load_o, sample_o, shift_o, done_o;

  spi_sck_gen dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .cpol_i    (cpol_i),
    .cpha_i    (cpha_i),
    .clk_div_i (clk_div_i),
    .bit_num_i (bit_num_i),
    .cs_dly_i  (cs_dly_i),
    .busy_o    (busy_o),
    .cs_n_o    (cs_n_o),
    .sck_o     (sck_o),
    .load_o    (load_o),
    .sample_o  (sample_o),
    .shift_o   (shift_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic        load;
    logic        sample;
    logic        shift;
    logic        done;
    logic        sck;
    logic        cs_n;
    logic        busy;
  } ev_t;

  ev_t  expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   edgeCount = 0;
  int   sampleCount = 0;
  int   shiftCount = 0;
  int   doneCount = 0;
  int   lastDoneCyc = 0;
  logic prevSck = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Expected events of one transfer, straight from the timing rules:
  // load at C, edge e at C+(D+e)*H, done at C+(2D+2N-1)*H. Events after
  // 'keep' are dropped (abort or reset cuts the transfer short).
  task automatic pushExpected(input int c, input logic pol, input logic pha,
                              input int h, input int n, input int d,
                              input int keep);
    ev_t ev;
    ev = '0;
    ev.cyc = c; ev.load = 1'b1; ev.sck = pol; ev.cs_n = 1'b0; ev.busy = 1'b1;
    if (c <= keep) expQ.push_back(ev);
    for (int e = 0; e < 2 * n; e++) begin
      ev = '0;
      ev.cyc  = c + (d + e) * h;
      ev.sck  = pol ^ ((e % 2) == 0);
      ev.cs_n = 1'b0;
      ev.busy = 1'b1;
      if ((e % 2) == 0) begin
        if (!pha) ev.sample = 1'b1; else ev.shift = 1'b1;
      end else begin
        if (!pha) ev.shift = (e != 2 * n - 1); else ev.sample = 1'b1;
      end
      if (ev.cyc <= keep) expQ.push_back(ev);
    end
    ev = '0;
    ev.cyc = c + (2 * d + 2 * n - 1) * h;
    ev.done = 1'b1; ev.sck = pol; ev.cs_n = 1'b1; ev.busy = 1'b0;
    if (ev.cyc <= keep) expQ.push_back(ev);
  endtask

  // Monitor: any pulse, or an SCK change while busy, is a DUT event.
  always @(negedge clk_i) begin
    ev_t obs;
    ev_t expEv;
    if (rst_n_i === 1'b1) begin
      obs.cyc = cyc; obs.load = load_o; obs.sample = sample_o;
      obs.shift = shift_o; obs.done = done_o; obs.sck = sck_o;
      obs.cs_n = cs_n_o; obs.busy = busy_o;
      if (load_o) begin
        edgeCount = 0; sampleCount = 0; shiftCount = 0;
      end
      if (busy_o && (sck_o != prevSck)) edgeCount++;
      if (sample_o) sampleCount++;
      if (shift_o) shiftCount++;
      if (done_o) begin
        doneCount++;
        lastDoneCyc = cyc;
      end
      if (load_o || sample_o || shift_o || done_o ||
          (busy_o && (sck_o != prevSck))) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_event actual=0x%0h required=none", obs);
        end else begin
          expEv = expQ.pop_front();
          checkOutput("event", 64'(obs), 64'(expEv));
        end
      end
    end
    prevSck = sck_o;
  end

  // One transfer with optional abort / reset at a given edge, a start pulse
  // while busy, and a config change mid-transfer.
  task automatic applyStimulus(input logic pol, input logic pha, input int div,
                               input int bn, input int dly,
                               input int abortEdge, input int resetEdge,
                               input bit busyStart, input bit cfgChange,
                               output int cOut);
    int h, n, d, c, x, abortCyc, resetCyc, stopCyc, busyCyc, cfgCyc;
    bit finished;
    h = div + 1;
    n = (bn == 0) ? 64 : bn;
    d = (dly == 0) ? 1 : dly;
    cpol_i = pol; cpha_i = pha; clk_div_i = 16'(div);
    bit_num_i = 6'(bn); cs_dly_i = 4'(dly);
    start_i = 1'b0; abort_i = 1'b0;
    repeat (2) @(negedge clk_i);
    c = cyc + 1;
    x = c + (2 * d + 2 * n - 1) * h;
    abortCyc = (abortEdge >= 0) ? c + (d + abortEdge) * h : -1;
    resetCyc = (resetEdge >= 0) ? c + (d + resetEdge) * h : -1;
    stopCyc = x;
    if (abortCyc >= 0 && abortCyc < stopCyc) stopCyc = abortCyc;
    if (resetCyc >= 0 && resetCyc < stopCyc) stopCyc = resetCyc;
    busyCyc = busyStart ? c + int'($urandom_range(0, stopCyc - c - 1)) : -1;
    cfgCyc  = cfgChange ? c + int'($urandom_range(0, stopCyc - c - 1)) : -1;
    pushExpected(c, pol, pha, h, n, d, stopCyc);
    cOut = c;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    finished = 1'b0;
    for (int k = 0; (k <= x - c + 4) && !finished; k++) begin
      start_i = 1'b0;
      if (cyc == busyCyc) start_i = 1'b1;
      if (cyc == cfgCyc) begin
        cpol_i = ~pol; cpha_i = ~pha; clk_div_i = 16'(div + 3);
        bit_num_i = 6'(bn + 5); cs_dly_i = 4'(dly + 7);
      end
      if (cyc == abortCyc) begin
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        start_i = 1'b0;
        checkOutput("abort_cs_n", 64'(cs_n_o), 64'(1));
        checkOutput("abort_busy", 64'(busy_o), 64'(0));
        checkOutput("abort_sck", 64'(sck_o), 64'(pol));
        checkOutput("abort_done", 64'(done_o), 64'(0));
        finished = 1'b1;
      end else if (cyc == resetCyc) begin
        #2 rst_n_i = 1'b0;
        #1;
        checkOutput("reset_outputs",
                    64'({sck_o, cs_n_o, busy_o, load_o, sample_o, shift_o, done_o}),
                    64'(7'b0100000));
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #2 rst_n_i = 1'b1;
        @(negedge clk_i);
        finished = 1'b1;
      end else if (cyc == x) begin
        checkOutput("done_pulse", 64'(done_o), 64'(1));
        checkOutput("done_cs_n", 64'(cs_n_o), 64'(1));
        checkOutput("done_busy", 64'(busy_o), 64'(0));
        finished = 1'b1;
      end else begin
        @(negedge clk_i);
      end
    end
    if (!finished) begin
      checks++;
      failures++;
      $display("[TB] FAIL transfer_timeout actual=cycle %0d required=end by %0d", cyc, x);
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c, d0, n, bn, ae;
    #1 rst_n_i = 1'b0;
    #2;
    checkOutput("reset_state",
                64'({sck_o, cs_n_o, busy_o, load_o, sample_o, shift_o, done_o}),
                64'(7'b0100000));
    repeat (3) @(negedge clk_i);
    #2 rst_n_i = 1'b1;
    @(negedge clk_i);

    // Mode 0, H=2, 8 bits, D=1: done at T+35.
    applyStimulus(1'b0, 1'b0, 1, 8, 1, -1, -1, 1'b0, 1'b0, c);
    checkOutput("m0_done_cycle", 64'(lastDoneCyc), 64'(c - 1 + 35));
    checkOutput("m0_edges", 64'(edgeCount), 64'(16));
    checkOutput("m0_samples", 64'(sampleCount), 64'(8));
    checkOutput("m0_shifts", 64'(shiftCount), 64'(7));

    // Mode 3, H=1, 4 bits, D=2: cs_n low 11 cycles.
    applyStimulus(1'b1, 1'b1, 0, 4, 2, -1, -1, 1'b0, 1'b0, c);
    checkOutput("m3_cs_low_cycles", 64'(lastDoneCyc - c), 64'(11));
    checkOutput("m3_samples", 64'(sampleCount), 64'(4));
    checkOutput("m3_shifts", 64'(shiftCount), 64'(4));
    checkOutput("m3_sck_idle", 64'(sck_o), 64'(1));

    // bit_num=0 means 64 bits.
    d0 = doneCount;
    applyStimulus(1'b0, 1'b0, 0, 0, 1, -1, -1, 1'b0, 1'b0, c);
    checkOutput("max_edges", 64'(edgeCount), 64'(128));
    checkOutput("max_samples", 64'(sampleCount), 64'(64));
    checkOutput("max_done_once", 64'(doneCount - d0), 64'(1));

    // Abort at 5th edge, then a normal transfer.
    d0 = doneCount;
    applyStimulus(1'b0, 1'b0, 1, 8, 1, 4, -1, 1'b0, 1'b0, c);
    checkOutput("abort_no_done", 64'(doneCount - d0), 64'(0));
    applyStimulus(1'b0, 1'b0, 1, 8, 1, -1, -1, 1'b0, 1'b0, c);
    checkOutput("after_abort_done_cycle", 64'(lastDoneCyc), 64'(c - 1 + 35));

    // start_i while busy.
    applyStimulus(1'b1, 1'b0, 2, 5, 3, -1, -1, 1'b1, 1'b0, c);

    // start_i and abort_i together in IDLE.
    cpol_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b0;
    checkOutput("idle_abort_busy", 64'(busy_o), 64'(0));
    checkOutput("idle_abort_cs_n", 64'(cs_n_o), 64'(1));
    checkOutput("idle_abort_load", 64'(load_o), 64'(0));
    repeat (4) @(negedge clk_i);
    checkOutput("idle_abort_still_idle", 64'(busy_o), 64'(0));

    // Config change mid-transfer, then reset mid-XFER, then a clean transfer.
    applyStimulus(1'b0, 1'b1, 2, 6, 2, -1, -1, 1'b0, 1'b1, c);
    applyStimulus(1'b1, 1'b0, 1, 8, 2, -1, 3, 1'b0, 1'b0, c);
    applyStimulus(1'b1, 1'b0, 1, 3, 1, -1, -1, 1'b0, 1'b0, c);

    // Randomised transfers.
    for (int i = 0; i < 20; i++) begin
      bn = int'($urandom_range(0, 12));
      n  = (bn == 0) ? 64 : bn;
      ae = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * n - 1)) : -1;
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), bn, int'($urandom_range(0, 5)),
                    ae, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c);
    end

    repeat (5) @(negedge clk_i);
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
